debounce_pulse_gen: RTL and testbench

//  N-channel push-button conditioner; successor to the 3-FF single-pulse generator.
//  Per channel: synchroniser, counter-based debounce, one-cycle edge pulse with

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_chan.sv | 137 +++++++++++++
 rtl/debounce_pulse_gen.sv | 54 +++++
 tb/tb_debounce_pulse_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants for the push-button conditioner: edge-select codes,
// repeat FSM states and a width helper.
package debounce_pkg;

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_BOTH = 2'd2;
  localparam logic [1:0] EDGE_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: synchroniser, counter debounce, edge pulse and
// auto-repeat FSM. o_pulseNext lets the parent register a same-cycle OR.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 3,
  parameter int HOLD_CYC    = 8,
  parameter int RPT_CYC     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inp,
  input  logic [1:0] i_edgeMode,
  input  logic       i_repeatEn,
  output logic       o_level,
  output logic       o_pulse,
  output logic       o_pulseNext
);

  localparam int CNT_W = $clog2(STABLE_CNT) + 1;
  localparam int TMR_W = $clog2(maxOf(HOLD_CYC, RPT_CYC)) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CNT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(RPT_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pulse;
  rpt_state_e             r_state;
  logic [TMR_W-1:0]       r_tmr;

  logic             w_s;
  logic             w_accept;
  logic             w_acceptRise;
  logic             w_acceptFall;
  logic             w_edgeHit;
  logic             w_rptPulse;
  rpt_state_e       w_stateNext;
  logic [TMR_W-1:0] w_tmrNext;

  assign w_s          = r_sync[SYNC_STAGES-1];
  assign w_accept     = (w_s != r_level) && (r_cnt == CNT_LAST);
  assign w_acceptRise = w_accept && w_s;
  assign w_acceptFall = w_accept && !w_s;

  // A new level is taken only after it has been seen STABLE_CNT edges in a row.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_inp};
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_edgeHit = 1'b0;
    if (w_accept) begin
      case (i_edgeMode)
        EDGE_RISE: w_edgeHit = w_s;
        EDGE_FALL: w_edgeHit = !w_s;
        EDGE_BOTH: w_edgeHit = 1'b1;
        default:   w_edgeHit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_tmr   <= w_tmrNext;
      r_pulse <= o_pulseNext;
    end
  end

  // Leaving HOLD/RPT takes priority, so the exit edge never also repeats.
  always_comb begin
    w_stateNext = r_state;
    w_tmrNext   = r_tmr;
    w_rptPulse  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acceptRise && i_repeatEn) begin
          w_stateNext = ST_HOLD;
          w_tmrNext   = '0;
        end
      end
      ST_HOLD: begin
        if (w_acceptFall || !i_repeatEn) begin
          w_stateNext = ST_IDLE;
          w_tmrNext   = '0;
        end else if (r_tmr == HOLD_LAST) begin
          w_rptPulse  = 1'b1;
          w_stateNext = ST_RPT;
          w_tmrNext   = '0;
        end else begin
          w_tmrNext = r_tmr + TMR_W'(1);
        end
      end
      ST_RPT: begin
        if (w_acceptFall || !i_repeatEn) begin
          w_stateNext = ST_IDLE;
          w_tmrNext   = '0;
        end else if (r_tmr == RPT_LAST) begin
          w_rptPulse = 1'b1;
          w_tmrNext  = '0;
        end else begin
          w_tmrNext = r_tmr + TMR_W'(1);
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_tmrNext   = '0;
      end
    endcase
  end

  assign o_pulseNext = w_edgeHit | w_rptPulse;
  assign o_level     = r_level;
  assign o_pulse     = r_pulse;

endmodule

// File: rtl/debounce_pulse_gen.sv
// N-channel push-button conditioner: independent debounce channels plus a
// registered any_pulse that lines up with the per-channel pulses.
module debounce_pulse_gen
  import debounce_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 3,
  parameter int HOLD_CYC    = 8,
  parameter int RPT_CYC     = 4
) (
  input  logic            clk_200H,
  input  logic            rst,
  input  logic [N_CH-1:0] inp,
  input  logic [1:0]      edge_mode,
  input  logic            repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic            any_pulse
);

  logic [N_CH-1:0] w_pulseNext;
  logic            r_anyPulse;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CNT (STABLE_CNT),
      .HOLD_CYC   (HOLD_CYC),
      .RPT_CYC    (RPT_CYC)
    ) u_chan (
      .i_clk      (clk_200H),
      .i_rst      (rst),
      .i_inp      (inp[g]),
      .i_edgeMode (edge_mode),
      .i_repeatEn (repeat_en),
      .o_level    (level[g]),
      .o_pulse    (pulse[g]),
      .o_pulseNext(w_pulseNext[g])
    );
  end

  // Built from the channels' next-pulse values so it asserts with them.
  always_ff @(posedge clk_200H) begin
    if (rst) begin
      r_anyPulse <= 1'b0;
    end else begin
      r_anyPulse <= |w_pulseNext;
    end
  end

  assign any_pulse = r_anyPulse;

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Scoreboard bench for debounce_pulse_gen: a window-based reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_debounce_pulse_gen;

  localparam int N_CH        = 2;
  localparam int SYNC_STAGES = 2;
  localparam int STABLE_CNT  = 3;
  localparam int HOLD_CYC    = 8;
  localparam int RPT_CYC     = 4;

  logic            clk_200H;
  logic            rst;
  logic [N_CH-1:0] inp;
  logic [1:0]      edge_mode;
  logic            repeat_en;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] pulse;
  logic            any_pulse;

  typedef struct packed {
    logic [N_CH-1:0] lvl;
    logic [N_CH-1:0] pls;
    logic            any;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   cyc     = 0;
  int   base    = 0;
  bit   logEn   = 0;
  int   rptLog[$];

  debounce_pulse_gen #(
    .N_CH       (N_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CNT (STABLE_CNT),
    .HOLD_CYC   (HOLD_CYC),
    .RPT_CYC    (RPT_CYC)
  ) dut (
    .clk_200H (clk_200H),
    .rst      (rst),
    .inp      (inp),
    .edge_mode(edge_mode),
    .repeat_en(repeat_en),
    .level    (level),
    .pulse    (pulse),
    .any_pulse(any_pulse)
  );

  initial begin
    clk_200H = 1'b0;
    forever #5 clk_200H = ~clk_200H;
  end

  always @(posedge clk_200H) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s at cyc %0d: actual %h required %h", name, cyc, act, req);
    end
  endtask

  // Reference model: history of raw input samples; the debounced level
  // follows the synchronised sample once the last STABLE_CNT of them agree
  // and differ from it. Repeats are timed from the accepted rise.
  logic [31:0]     hist [N_CH];
  logic [N_CH-1:0] mLvl;
  bit              armed [N_CH];
  int              age [N_CH];

  always @(posedge clk_200H) begin
    exp_t e;
    logic v, acc, eHit, rHit;
    e = '0;
    if (rst) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        hist[ch]  = '0;
        armed[ch] = 0;
        age[ch]   = 0;
      end
      mLvl = '0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        hist[ch] = {hist[ch][30:0], inp[ch]};
        v   = hist[ch][SYNC_STAGES];
        acc = (v != mLvl[ch]);
        for (int k = 1; k < STABLE_CNT; k++)
          if (hist[ch][SYNC_STAGES+k] != v) acc = 1'b0;
        eHit = acc && ((edge_mode == 2'd0 && v) || (edge_mode == 2'd1 && !v) ||
                       (edge_mode == 2'd2));
        rHit = 1'b0;
        if (armed[ch]) begin
          if ((acc && !v) || !repeat_en) begin
            armed[ch] = 0;
          end else begin
            age[ch]++;
            if (age[ch] == HOLD_CYC ||
                (age[ch] > HOLD_CYC && (age[ch] - HOLD_CYC) % RPT_CYC == 0))
              rHit = 1'b1;
          end
        end else if (acc && v && repeat_en) begin
          armed[ch] = 1;
          age[ch]   = 0;
        end
        if (acc) mLvl[ch] = v;
        e.pls[ch] = eHit | rHit;
      end
      e.lvl = mLvl;
      e.any = |e.pls;
    end
    expQ.push_back(e);
  end

  // Monitor: one expected entry per clock edge, compared mid-cycle.
  always @(negedge clk_200H) begin
    exp_t e;
    if (expQ.size() == 0) begin
      if (cyc > 0) checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput("outputs", 32'({level, pulse, any_pulse}), 32'({e.lvl, e.pls, e.any}));
      if (logEn && pulse[1]) rptLog.push_back(cyc - base - 1);
    end
  end

  // Called at a negedge; drives inputs, then advances nCyc negedges.
  task automatic applyStimulus(input logic [N_CH-1:0] vInp, input logic [1:0] vMode,
                               input logic vRpt, input logic vRst, input int nCyc);
    inp       = vInp;
    edge_mode = vMode;
    repeat_en = vRpt;
    rst       = vRst;
    repeat (nCyc) @(negedge clk_200H);
  endtask

  int expOffs[7] = '{4, 12, 16, 20, 24, 28, 32};

  initial begin
    inp = '0; edge_mode = 2'd0; repeat_en = 1'b0; rst = 1'b1;
    @(negedge clk_200H);
    applyStimulus(2'b00, 2'd0, 1'b0, 1'b1, 2);
    applyStimulus(2'b00, 2'd0, 1'b0, 1'b0, 4);

    $display("[TB] bounce on channel 0");
    for (int i = 0; i < 10; i++) applyStimulus(2'(i % 2 == 0), 2'd2, 1'b0, 1'b0, 1);
    applyStimulus(2'b00, 2'd2, 1'b0, 1'b0, 8);

    $display("[TB] clean rise and fall modes");
    applyStimulus(2'b01, 2'd0, 1'b0, 1'b0, 8);
    applyStimulus(2'b00, 2'd1, 1'b0, 1'b0, 8);
    applyStimulus(2'b01, 2'd0, 1'b0, 1'b0, 8);
    applyStimulus(2'b00, 2'd0, 1'b0, 1'b0, 8);
    applyStimulus(2'b01, 2'd3, 1'b0, 1'b0, 8);
    applyStimulus(2'b00, 2'd3, 1'b0, 1'b0, 8);

    $display("[TB] auto-repeat on channel 1");
    rptLog.delete();
    base  = cyc;
    logEn = 1;
    applyStimulus(2'b10, 2'd0, 1'b1, 1'b0, 30);
    applyStimulus(2'b00, 2'd0, 1'b1, 1'b0, 16);
    logEn = 0;
    checkOutput("repeat_count", 32'(rptLog.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < rptLog.size()) checkOutput("repeat_offset", 32'(rptLog[i]), 32'(expOffs[i]));

    applyStimulus(2'b10, 2'd0, 1'b1, 1'b0, 20);
    rptLog.delete();
    logEn = 1;
    applyStimulus(2'b10, 2'd0, 1'b0, 1'b0, 10);
    applyStimulus(2'b00, 2'd0, 1'b0, 1'b0, 10);
    logEn = 0;
    checkOutput("repeat_stopped", 32'(rptLog.size()), 32'd0);

    $display("[TB] both channels together");
    applyStimulus(2'b11, 2'd0, 1'b0, 1'b0, 8);
    applyStimulus(2'b00, 2'd2, 1'b0, 1'b0, 8);

    $display("[TB] reset mid-hold");
    applyStimulus(2'b01, 2'd0, 1'b1, 1'b0, 10);
    applyStimulus(2'b01, 2'd0, 1'b1, 1'b1, 2);
    applyStimulus(2'b01, 2'd0, 1'b1, 1'b0, 20);
    applyStimulus(2'b00, 2'd0, 1'b1, 1'b0, 8);

    $display("[TB] random phase");
    for (int i = 0; i < 1500; i++) begin
      logic [N_CH-1:0] nInp;
      logic [1:0]      nMode;
      logic            nRpt;
      nInp  = inp;
      nMode = edge_mode;
      nRpt  = repeat_en;
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, 5) == 0) nInp[ch] = ~nInp[ch];
      if ($urandom_range(0, 39) == 0) nMode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) nRpt = ~nRpt;
      applyStimulus(nInp, nMode, nRpt, 1'($urandom_range(0, 299) == 0), 1);
    end
    applyStimulus(2'b00, 2'd0, 1'b0, 1'b0, 6);

    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
